// File: rtl/io_read_arbiter_pkg.sv
// Shared types and constants for the CPU I/O read arbiter.
// Holds the FSM state encoding and the idle level of the data bus.
package io_read_arbiter_pkg;

    typedef enum logic [1:0] {
        IO_ARB_IDLE    = 2'd0,
        IO_ARB_SAMPLE  = 2'd1,
        IO_ARB_DRIVE   = 2'd2,
        IO_ARB_RELEASE = 2'd3
    } io_arb_state_t;

    localparam logic [7:0] IO_ARB_BUS_IDLE = 8'hFF;

    // Settle and turnaround counts both fit in 1..7.
    localparam int unsigned IO_ARB_TCNT_W = 3;

endpackage

// File: rtl/io_read_arbiter_if.sv
// CPU bus control strobes seen by the I/O read arbiter.
// The CPU model drives them; the arbiter only observes.
interface cpu_bus;
    import io_read_arbiter_pkg::*;

    logic ioreq;
    logic rd;
    logic m1;

    modport master (
        output ioreq,
        output rd,
        output m1
    );

    modport slave (
        input ioreq,
        input rd,
        input m1
    );

endinterface

// File: rtl/io_read_arbiter_prio_enc.sv
// Fixed-priority encoder: index 0 wins; also flags any claim and multiple claims.
// Purely combinational.
module io_prio_enc
    import io_read_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] active,
    output logic [N-1:0] grant,
    output logic         any,
    output logic         multi
);

    logic seen;

    // Walk from highest priority; first set bit wins, any later set bit marks a conflict.
    always_comb begin
        grant = {N{1'b0}};
        multi = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < N; i++) begin
            grant[i] = active[i] & ~seen;
            multi    = multi | (active[i] & seen);
            seen     = seen | active[i];
        end
        any = seen;
    end

endmodule

// File: rtl/io_read_arbiter.sv
// Schedules CPU I/O read cycles across N responders: settle, pick by priority,
// latch and drive the winner's byte, then hold the bus off for a turnaround.
module io_read_arbiter
    import io_read_arbiter_pkg::*;
#(
    parameter int N      = 4,
    parameter int SETTLE = 2,
    parameter int TURN   = 1,
    parameter int CNT_W  = 8
) (
    input  logic                  clk28,
    input  logic                  rst_n,
    cpu_bus.slave                 bus,
    input  logic [N-1:0][7:0]     req_d,
    input  logic [N-1:0]          req_active,
    input  logic                  default_en,
    input  logic [7:0]            default_d,
    input  logic                  conflict_clr,
    output logic [7:0]            d_out,
    output logic                  d_out_oe,
    output logic [N-1:0]          grant,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam logic [IO_ARB_TCNT_W-1:0] SETTLE_LAST = IO_ARB_TCNT_W'(SETTLE - 1);
    localparam logic [IO_ARB_TCNT_W-1:0] TURN_LAST   = IO_ARB_TCNT_W'(TURN - 1);
    localparam logic [IO_ARB_TCNT_W-1:0] TCNT_ONE    = IO_ARB_TCNT_W'(1);
    localparam logic [CNT_W-1:0]         CONF_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]         CONF_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    io_arb_state_t            state_r;
    io_arb_state_t            state_s;
    logic [IO_ARB_TCNT_W-1:0] cnt_r;
    logic [IO_ARB_TCNT_W-1:0] cnt_s;
    logic [7:0]               d_out_s;
    logic                     oe_s;
    logic [N-1:0]             grant_s;
    logic [CNT_W-1:0]         conf_s;
    logic                     sample_fire_s;
    logic                     rd_cyc_s;
    logic [N-1:0]             enc_grant_s;
    logic                     enc_any_s;
    logic                     enc_multi_s;
    logic [7:0]               win_d_s;

    // Interrupt acknowledge also asserts ioreq; m1 excludes it.
    assign rd_cyc_s = bus.ioreq & bus.rd & ~bus.m1;

    io_prio_enc #(
        .N (N)
    ) u_prio_enc (
        .active (req_active),
        .grant  (enc_grant_s),
        .any    (enc_any_s),
        .multi  (enc_multi_s)
    );

    // One-hot select of the winning responder's byte.
    always_comb begin
        win_d_s = 8'h00;
        for (int i = 0; i < N; i++) begin
            win_d_s = win_d_s | (req_d[i] & {8{enc_grant_s[i]}});
        end
    end

    // Next-state, counter and latch updates for the read-cycle FSM.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        d_out_s       = d_out;
        oe_s          = d_out_oe;
        grant_s       = grant;
        sample_fire_s = 1'b0;
        case (state_r)
            IO_ARB_IDLE: begin
                oe_s = 1'b0;
                if (rd_cyc_s) begin
                    state_s = IO_ARB_SAMPLE;
                    cnt_s   = {IO_ARB_TCNT_W{1'b0}};
                end else begin
                    state_s = IO_ARB_IDLE;
                end
            end
            IO_ARB_SAMPLE: begin
                oe_s = 1'b0;
                if (!rd_cyc_s) begin
                    state_s = IO_ARB_IDLE;
                end else if (cnt_r == SETTLE_LAST) begin
                    sample_fire_s = 1'b1;
                    grant_s       = enc_grant_s;
                    if (enc_any_s) begin
                        d_out_s = win_d_s;
                        oe_s    = 1'b1;
                        state_s = IO_ARB_DRIVE;
                    end else if (default_en) begin
                        d_out_s = default_d;
                        oe_s    = 1'b1;
                        state_s = IO_ARB_DRIVE;
                    end else begin
                        // Nobody answers and floating data is off: leave the bus alone.
                        state_s = IO_ARB_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + TCNT_ONE;
                end
            end
            IO_ARB_DRIVE: begin
                if (!rd_cyc_s) begin
                    oe_s    = 1'b0;
                    cnt_s   = {IO_ARB_TCNT_W{1'b0}};
                    state_s = IO_ARB_RELEASE;
                end else begin
                    oe_s    = 1'b1;
                    state_s = IO_ARB_DRIVE;
                end
            end
            IO_ARB_RELEASE: begin
                oe_s = 1'b0;
                if (cnt_r == TURN_LAST) begin
                    state_s = IO_ARB_IDLE;
                end else begin
                    cnt_s = cnt_r + TCNT_ONE;
                end
            end
            default: begin
                oe_s    = 1'b0;
                state_s = IO_ARB_IDLE;
            end
        endcase
    end

    // Saturating multi-claim counter; a clear wins over a same-cycle increment.
    always_comb begin
        if (conflict_clr) begin
            conf_s = {CNT_W{1'b0}};
        end else if (sample_fire_s && enc_multi_s && (conflict_cnt != CONF_MAX)) begin
            conf_s = conflict_cnt + CONF_ONE;
        end else begin
            conf_s = conflict_cnt;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state_r      <= IO_ARB_IDLE;
            cnt_r        <= {IO_ARB_TCNT_W{1'b0}};
            d_out        <= IO_ARB_BUS_IDLE;
            d_out_oe     <= 1'b0;
            grant        <= {N{1'b0}};
            conflict_cnt <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            d_out        <= d_out_s;
            d_out_oe     <= oe_s;
            grant        <= grant_s;
            conflict_cnt <= conf_s;
        end
    end

endmodule

// File: tb/tb_io_read_arbiter.sv
// Self-checking bench for io_read_arbiter: directed vector table, hand-written
// corner sequences and randomized reads against a transaction-level model.
module tb_io_read_arbiter;

    localparam int N      = 4;
    localparam int SETTLE = 2;
    localparam int TURN   = 1;
    localparam int CNT_W  = 8;

    logic                 clk28;
    logic                 rst_n;
    logic [N-1:0][7:0]    req_d;
    logic [N-1:0]         req_active;
    logic                 default_en;
    logic [7:0]           default_d;
    logic                 conflict_clr;
    logic [7:0]           d_out;
    logic                 d_out_oe;
    logic [N-1:0]         grant;
    logic [CNT_W-1:0]     conflict_cnt;

    cpu_bus bus_if ();

    io_read_arbiter #(
        .N      (N),
        .SETTLE (SETTLE),
        .TURN   (TURN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .req_d        (req_d),
        .req_active   (req_active),
        .default_en   (default_en),
        .default_d    (default_d),
        .conflict_clr (conflict_clr),
        .d_out        (d_out),
        .d_out_oe     (d_out_oe),
        .grant        (grant),
        .conflict_cnt (conflict_cnt)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int             len;
        logic [3:0]     act;
        logic [3:0][7:0] d;
        logic           def_en;
        logic [7:0]     def_d;
        int             exp_oe;
        logic [7:0]     exp_d;
        logic [3:0]     exp_g;
        logic [7:0]     exp_conf;
    } vec_t;

    vec_t vecs [9];

    // transaction-level model state
    logic [7:0]   m_d;
    logic [N-1:0] m_grant;
    int           m_conf;

    task automatic step();
        @(posedge clk28);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold a read for len edges, then idle long enough to clear the turnaround.
    task automatic run_read(input int len, output int oe_cycles);
        oe_cycles    = 0;
        bus_if.ioreq = 1'b1;
        bus_if.rd    = 1'b1;
        bus_if.m1    = 1'b0;
        for (int k = 0; k < len; k++) begin
            step();
            if (d_out_oe) oe_cycles++;
        end
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        for (int k = 0; k < TURN + 3; k++) begin
            step();
            if (d_out_oe) oe_cycles++;
        end
    endtask

    // Predicts one read from the arbitration rules and updates model state.
    task automatic model_read(input int len, input logic [N-1:0] act, input logic [N-1:0][7:0] d,
                              input logic def_en, input logic [7:0] def_d, output int exp_oe);
        int winner;
        exp_oe = 0;
        if (len > SETTLE) begin
            winner = -1;
            for (int i = 0; i < N; i++) begin
                if (act[i] && winner < 0) winner = i;
            end
            if (winner >= 0) begin
                m_grant = N'(1) << winner;
                m_d     = d[winner];
                exp_oe  = len - SETTLE;
            end else begin
                m_grant = '0;
                if (def_en) begin
                    m_d    = def_d;
                    exp_oe = len - SETTLE;
                end
            end
            if ($countones(act) >= 2 && m_conf < 255) m_conf++;
        end
    endtask

    initial begin
        int oe_cnt;
        int gap;
        int lat;
        int exp_oe;

        vecs[0] = '{20, 4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b0, 8'h00, 18, 8'h5A, 4'b0100, 8'd0};
        vecs[1] = '{ 6, 4'b1010, {8'h33, 8'h00, 8'h11, 8'h00}, 1'b0, 8'h00,  4, 8'h11, 4'b0010, 8'd1};
        vecs[2] = '{ 5, 4'b0000, {8'h12, 8'h34, 8'h56, 8'h78}, 1'b1, 8'hC7,  3, 8'hC7, 4'b0000, 8'd1};
        vecs[3] = '{ 5, 4'b0000, {8'h12, 8'h34, 8'h56, 8'h78}, 1'b0, 8'h99,  0, 8'hC7, 4'b0000, 8'd1};
        vecs[4] = '{ 1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h77}, 1'b1, 8'hE1,  0, 8'hC7, 4'b0000, 8'd1};
        vecs[5] = '{ 2, 4'b0011, {8'h00, 8'h00, 8'hB2, 8'hA1}, 1'b1, 8'hE2,  0, 8'hC7, 4'b0000, 8'd1};
        vecs[6] = '{ 3, 4'b0011, {8'h00, 8'h00, 8'hB2, 8'hA1}, 1'b0, 8'h00,  1, 8'hA1, 4'b0001, 8'd2};
        vecs[7] = '{ 4, 4'b1000, {8'h3C, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h00,  2, 8'h3C, 4'b1000, 8'd2};
        vecs[8] = '{ 4, 4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hF0}, 1'b0, 8'h00,  2, 8'hF0, 4'b0001, 8'd3};

        rst_n        = 1'b0;
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        bus_if.m1    = 1'b0;
        req_d        = '0;
        req_active   = '0;
        default_en   = 1'b0;
        default_d    = 8'h00;
        conflict_clr = 1'b0;
        step(); step(); step();
        check("rst_d_out", 32'(d_out), 32'hFF);
        check("rst_oe", 32'(d_out_oe), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_conf", 32'(conflict_cnt), 32'h0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 9; v++) begin
            req_active = vecs[v].act;
            req_d      = vecs[v].d;
            default_en = vecs[v].def_en;
            default_d  = vecs[v].def_d;
            run_read(vecs[v].len, oe_cnt);
            check($sformatf("tbl%0d_oe_cycles", v), 32'(oe_cnt), 32'(vecs[v].exp_oe));
            check($sformatf("tbl%0d_d_out", v), 32'(d_out), 32'(vecs[v].exp_d));
            check($sformatf("tbl%0d_grant", v), 32'(grant), 32'(vecs[v].exp_g));
            check($sformatf("tbl%0d_conf", v), 32'(conflict_cnt), 32'(vecs[v].exp_conf));
        end

        // latched byte must ignore responder changes while driving
        default_en   = 1'b0;
        req_active   = 4'b0001;
        req_d        = {8'h00, 8'h00, 8'h00, 8'hAA};
        bus_if.ioreq = 1'b1;
        bus_if.rd    = 1'b1;
        step(); step(); step(); step(); step();
        req_d      = {8'h00, 8'h00, 8'h66, 8'h55};
        req_active = 4'b0010;
        step(); step(); step();
        check("stab_oe", 32'(d_out_oe), 32'h1);
        check("stab_d_out", 32'(d_out), 32'hAA);
        check("stab_grant", 32'(grant), 32'h1);
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        step();
        check("stab_oe_fall", 32'(d_out_oe), 32'h0);
        for (int k = 0; k < TURN + 3; k++) step();

        // interrupt acknowledge and write cycles are ignored
        req_active   = 4'b1111;
        oe_cnt       = 0;
        bus_if.ioreq = 1'b1;
        bus_if.rd    = 1'b1;
        bus_if.m1    = 1'b1;
        for (int k = 0; k < 10; k++) begin step(); if (d_out_oe) oe_cnt++; end
        bus_if.m1 = 1'b0;
        bus_if.rd = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (d_out_oe) oe_cnt++; end
        bus_if.ioreq = 1'b0;
        step();
        check("m1_wr_oe_cycles", 32'(oe_cnt), 32'h0);
        check("m1_wr_conf", 32'(conflict_cnt), 32'd3);

        // back-to-back: read restarts during the turnaround
        req_active   = 4'b0001;
        req_d        = {8'h00, 8'h00, 8'h00, 8'h4D};
        bus_if.ioreq = 1'b1;
        bus_if.rd    = 1'b1;
        for (int k = 0; k < 5; k++) step();
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        step();
        check("b2b_oe_fall", 32'(d_out_oe), 32'h0);
        bus_if.ioreq = 1'b1;
        bus_if.rd    = 1'b1;
        gap = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (d_out_oe) break;
            gap++;
        end
        check("b2b_oe_gap", 32'(gap), 32'(TURN + 1 + SETTLE));
        check("b2b_d_out", 32'(d_out), 32'h4D);
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        for (int k = 0; k < TURN + 3; k++) step();

        // saturation of the conflict counter from 3
        req_active = 4'b1010;
        req_d      = {8'h33, 8'h00, 8'h11, 8'h00};
        for (int j = 1; j <= 300; j++) begin
            run_read(3, oe_cnt);
            if (j == 251) check("sat_conf_254", 32'(conflict_cnt), 32'd254);
        end
        check("sat_conf_255", 32'(conflict_cnt), 32'd255);
        check("sat_d_out", 32'(d_out), 32'h11);
        conflict_clr = 1'b1;
        step();
        conflict_clr = 1'b0;
        step();
        check("clr_conf", 32'(conflict_cnt), 32'd0);
        conflict_clr = 1'b1;
        run_read(4, oe_cnt);
        conflict_clr = 1'b0;
        check("clr_prio_conf", 32'(conflict_cnt), 32'd0);
        check("clr_prio_oe_cycles", 32'(oe_cnt), 32'd2);

        // reset while driving, then a read held across reset release
        req_active   = 4'b0100;
        req_d        = {8'h00, 8'h5A, 8'h00, 8'h00};
        bus_if.ioreq = 1'b1;
        bus_if.rd    = 1'b1;
        step(); step(); step(); step();
        check("rstdrv_oe_before", 32'(d_out_oe), 32'h1);
        rst_n = 1'b0;
        step();
        check("rstdrv_oe", 32'(d_out_oe), 32'h0);
        check("rstdrv_d_out", 32'(d_out), 32'hFF);
        check("rstdrv_grant", 32'(grant), 32'h0);
        rst_n = 1'b1;
        lat   = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            lat++;
            if (d_out_oe) break;
        end
        check("rstdrv_latency", 32'(lat), 32'(SETTLE + 1));
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        for (int k = 0; k < TURN + 3; k++) step();

        // randomized reads against the model from a clean reset
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        m_d     = 8'hFF;
        m_grant = '0;
        m_conf  = 0;
        for (int t = 0; t < 150; t++) begin
            int len;
            len        = int'($urandom_range(1, 8));
            req_active = N'($urandom);
            req_d      = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            default_en = 1'($urandom);
            default_d  = 8'($urandom);
            model_read(len, req_active, req_d, default_en, default_d, exp_oe);
            run_read(len, oe_cnt);
            check($sformatf("rnd%0d_oe_cycles", t), 32'(oe_cnt), 32'(exp_oe));
            check($sformatf("rnd%0d_d_out", t), 32'(d_out), 32'(m_d));
            check($sformatf("rnd%0d_grant", t), 32'(grant), 32'(m_grant));
            check($sformatf("rnd%0d_conf", t), 32'(conflict_cnt), 32'(m_conf));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
